agat9_kbd_host: RTL and testbench

Computer-side end of the Agat-9 keyboard link, i.e. the host-side receiver for the keyboard connector. It generates the keyboard clock (Гкл) and drives the reply line (Ответ). It deserializes codes arriving on the keyboard data line (Данные), synchronizes the keyboard reset (Сброс) and Р/Л status lines, and hands 7-bit key codes to the system bus through a one-entry valid/ready buffer.

---
 rtl/agat9_kbd_host_pkg.sv | 15 +
 rtl/agat9_kbd_host_sync2.sv | 24 ++
 rtl/agat9_kbd_host.sv | 126 ++++++++++++
 tb/tb_agat9_kbd_host.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/agat9_kbd_host_pkg.sv
// Shared definitions for the Agat-9 keyboard host: receiver states and frame geometry.
// Combinational constants only; no latency, no flow control.
package agat9_kbd_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  localparam int KBD_FRAME_BITS = 9;
  localparam int KBD_DATA_BITS  = 7;
  localparam int KBD_CLK_DIV    = 32;

endpackage

// File: rtl/agat9_kbd_host_sync2.sv
// Two-flop synchronizer with a selectable reset value for asynchronous keyboard pins.
// Latency 2 clocks; no flow control.
module agat9_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/agat9_kbd_host.sv
// Agat-9 keyboard host: drives Гкл, deserializes start/7-bit/stop frames into a one-entry buffer.
// code_valid rises 1 clock after the stop-bit strobe; a full buffer drops the frame and pulses overrun.
module agat9_kbd_host
  import agat9_kbd_host_pkg::*;
#(
  parameter int CLK_DIV   = KBD_CLK_DIV,
  parameter int DATA_BITS = KBD_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 kbd_clock,
  output logic                 kbd_reply,
  input  logic                 kbd_data,
  input  logic                 kbd_reset_in,
  input  logic                 kbd_ruslat_in,
  output logic [DATA_BITS-1:0] code,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 kbd_reset,
  output logic                 ruslat
);

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic [9:0]           div_cnt;
  logic                 strobe;
  logic                 data_s;
  logic                 reset_in_s;
  rx_state_t            state;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  agat9_sync2 #(.RST_VAL(1'b1)) u_sync_data (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (kbd_data),
    .q       (data_s)
  );

  agat9_sync2 #(.RST_VAL(1'b1)) u_sync_reset (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (kbd_reset_in),
    .q       (reset_in_s)
  );

  agat9_sync2 #(.RST_VAL(1'b0)) u_sync_ruslat (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (kbd_ruslat_in),
    .q       (ruslat)
  );

  assign kbd_reset = ~reset_in_s;

  // Strobe marks the cycle whose closing edge raises kbd_clock; the FSM samples on that edge.
  assign strobe = ~kbd_clock && (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      kbd_clock <= 1'b1;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      kbd_clock <= ~kbd_clock;
    end else begin
      div_cnt <= div_cnt + 10'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      kbd_reply  <= 1'b1;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      kbd_reply <= ~code_valid;

      if (code_valid && code_ready)
        code_valid <= 1'b0;

      if (kbd_reset) begin
        state <= ST_IDLE;
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST)
              state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!data_s) begin
              frame_err <= 1'b1;
            end else if (!code_valid || code_ready) begin
              // A same-cycle accept frees the slot, so the new code overrides the clear above.
              code       <= shreg;
              code_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agat9_kbd_host.sv
// Directed bench for agat9_kbd_host: a default-divider instance plus a CLK_DIV=4 instance.
module tb_agat9_kbd_host;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       kbd_clock, kbd_reply, kbd_data, kbd_reset_in, kbd_ruslat_in;
  logic [6:0] code;
  logic       code_valid, code_ready, overrun, frame_err, kbd_reset, ruslat;

  logic       b_kbd_clock, b_kbd_reply, b_kbd_data, b_kbd_reset_in, b_kbd_ruslat_in;
  logic [6:0] b_code;
  logic       b_code_valid, b_code_ready, b_overrun, b_frame_err, b_kbd_reset, b_ruslat;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  agat9_kbd_host dut (
    .clock(clock), .reset_n(reset_n), .kbd_clock(kbd_clock), .kbd_reply(kbd_reply),
    .kbd_data(kbd_data), .kbd_reset_in(kbd_reset_in), .kbd_ruslat_in(kbd_ruslat_in),
    .code(code), .code_valid(code_valid), .code_ready(code_ready), .overrun(overrun),
    .frame_err(frame_err), .kbd_reset(kbd_reset), .ruslat(ruslat)
  );

  agat9_kbd_host #(.CLK_DIV(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .kbd_clock(b_kbd_clock), .kbd_reply(b_kbd_reply),
    .kbd_data(b_kbd_data), .kbd_reset_in(b_kbd_reset_in), .kbd_ruslat_in(b_kbd_ruslat_in),
    .code(b_code), .code_valid(b_code_valid), .code_ready(b_code_ready), .overrun(b_overrun),
    .frame_err(b_frame_err), .kbd_reset(b_kbd_reset), .ruslat(b_ruslat)
  );

  // Monitors sample on the falling system-clock edge, away from the active edge.
  int         cyc = 0;
  int         ovr_cnt = 0, ferr_cnt = 0, b_ovr_cnt = 0;
  logic       b_prev_k = 1'b1;
  int         b_last_rise = 0, b_period = 0, b_bad = 0, b_rises = 0;
  logic [6:0] b_got[$];

  always @(negedge clock) begin
    cyc++;
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (b_overrun === 1'b1) b_ovr_cnt++;
    if (!b_prev_k && b_kbd_clock === 1'b1) begin
      if (b_rises > 0) begin
        b_period = cyc - b_last_rise;
        if (b_period != 8) b_bad++;
      end
      b_rises++;
      b_last_rise = cyc;
    end
    b_prev_k = b_kbd_clock;
    if (b_code_valid === 1'b1 && b_code_ready === 1'b1) b_got.push_back(b_code);
  end

  function automatic logic kclk(input int which);
    return (which != 0) ? b_kbd_clock : kbd_clock;
  endfunction

  task automatic set_data(input int which, input logic v);
    if (which != 0) b_kbd_data = v;
    else kbd_data = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_edge(input int which, input logic rise);
    logic prev;
    bit   seen;
    prev = kclk(which);
    seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      tick();
      if (kclk(which) == rise && prev != rise) seen = 1'b1;
      prev = kclk(which);
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL kclk_edge_timeout: dut%0d no %s of kbd_clock within 1000 cycles", which, rise ? "rise" : "fall");
    end
  endtask

  // Keyboard side: change the data line right after each kbd_clock fall.
  task automatic send_bits(input int which, input logic [8:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      wait_edge(which, 1'b0);
      set_data(which, frame[i]);
    end
  endtask

  // Returns just after the edge on which the host sampled the stop bit.
  task automatic send_frame(input int which, input logic [6:0] c, input logic stop);
    send_bits(which, {stop, c, 1'b0}, 9);
    wait_edge(which, 1'b1);
    set_data(which, 1'b1);
  endtask

  task automatic drain();
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    tick();
  endtask

  task automatic count_first_fall();
    int n;
    n = 0;
    while (kbd_clock === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32) begin fails++; $display("FAIL first_fall: got %0d cycles, expected 32", n); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    kbd_data = 1'b1; kbd_reset_in = 1'b1; kbd_ruslat_in = 1'b0; code_ready = 1'b0;
    b_kbd_data = 1'b1; b_kbd_reset_in = 1'b1; b_kbd_ruslat_in = 1'b0; b_code_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({kbd_clock, kbd_reply} !== 2'b11) begin fails++; $display("FAIL reset_clk_reply: got %b, expected 11", {kbd_clock, kbd_reply}); end
    checks++;
    if ({code, code_valid} !== 8'h00) begin fails++; $display("FAIL reset_code: got %h, expected 00", {code, code_valid}); end
    checks++;
    if ({overrun, frame_err, kbd_reset, ruslat} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b, expected 0000", {overrun, frame_err, kbd_reset, ruslat}); end
    reset_n = 1'b1;
    count_first_fall();
  endtask

  task automatic test_single_frame();
    send_frame(0, 7'h41, 1'b1);
    checks++;
    if ({code_valid, code} !== {1'b1, 7'h41}) begin fails++; $display("FAIL single_code: got v=%b code=%h, expected v=1 code=41", code_valid, code); end
    checks++;
    if (kbd_reply !== 1'b1) begin fails++; $display("FAIL single_reply_lag: got %b, expected 1", kbd_reply); end
    tick();
    checks++;
    if (kbd_reply !== 1'b0) begin fails++; $display("FAIL single_reply: got %b, expected 0", kbd_reply); end
  endtask

  task automatic test_overrun();
    int o0;
    drain();
    checks++;
    if ({code_valid, kbd_reply} !== 2'b01) begin fails++; $display("FAIL drain: got v/reply=%b, expected 01", {code_valid, kbd_reply}); end
    o0 = ovr_cnt;
    send_frame(0, 7'h41, 1'b1);
    send_frame(0, 7'h2A, 1'b1);
    checks++;
    if ({overrun, code_valid, code} !== {2'b11, 7'h41}) begin fails++; $display("FAIL overrun_pulse: got ovr=%b v=%b code=%h, expected 1 1 41", overrun, code_valid, code); end
    tick();
    checks++;
    if (overrun !== 1'b0 || ovr_cnt - o0 !== 1) begin fails++; $display("FAIL overrun_once: got ovr=%b count=%0d, expected 0 and 1", overrun, ovr_cnt - o0); end
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    checks++;
    if (code_valid !== 1'b0) begin fails++; $display("FAIL accept_clear: got %b, expected 0", code_valid); end
    tick();
    checks++;
    if (kbd_reply !== 1'b1) begin fails++; $display("FAIL accept_reply: got %b, expected 1", kbd_reply); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cnt;
    send_frame(0, 7'h33, 1'b0);
    checks++;
    if ({frame_err, code_valid} !== 2'b10) begin fails++; $display("FAIL ferr_pulse: got ferr/v=%b, expected 10", {frame_err, code_valid}); end
    tick();
    checks++;
    if (frame_err !== 1'b0 || ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_once: got ferr=%b count=%0d, expected 0 and 1", frame_err, ferr_cnt - f0); end
    send_frame(0, 7'h7F, 1'b1);
    checks++;
    if ({code_valid, code} !== {1'b1, 7'h7F}) begin fails++; $display("FAIL after_ferr: got v=%b code=%h, expected v=1 code=7f", code_valid, code); end
    drain();
  endtask

  task automatic test_kbd_reset();
    int o0;
    o0 = ovr_cnt;
    send_bits(0, {1'b1, 7'h6B, 1'b0}, 5);
    repeat (3) tick();
    kbd_reset_in = 1'b0;
    set_data(0, 1'b1);
    tick();
    checks++;
    if (kbd_reset !== 1'b0) begin fails++; $display("FAIL kbd_reset_early: got %b, expected 0", kbd_reset); end
    tick();
    checks++;
    if (kbd_reset !== 1'b1) begin fails++; $display("FAIL kbd_reset_sync: got %b, expected 1", kbd_reset); end
    repeat (200) tick();
    kbd_reset_in = 1'b1;
    repeat (4) tick();
    checks++;
    if ({kbd_reset, code_valid} !== 2'b00) begin fails++; $display("FAIL kbd_reset_discard: got rst/v=%b, expected 00", {kbd_reset, code_valid}); end
    send_frame(0, 7'h15, 1'b1);
    checks++;
    if ({code_valid, code} !== {1'b1, 7'h15} || ovr_cnt != o0) begin fails++; $display("FAIL after_kbd_reset: got v=%b code=%h ovr=%0d, expected v=1 code=15 ovr=0", code_valid, code, ovr_cnt - o0); end
    drain();
  endtask

  task automatic test_back_to_back();
    int n0, bad0, r0, o0;
    n0 = b_got.size(); bad0 = b_bad; r0 = b_rises; o0 = b_ovr_cnt;
    send_frame(1, 7'h00, 1'b1);
    send_frame(1, 7'h55, 1'b1);
    send_frame(1, 7'h7F, 1'b1);
    repeat (5) tick();
    checks++;
    if (b_got.size() - n0 !== 3) begin fails++; $display("FAIL b2b_count: got %0d, expected 3", b_got.size() - n0); end
    else begin
      checks++;
      if ({b_got[n0], b_got[n0+1], b_got[n0+2]} !== {7'h00, 7'h55, 7'h7F}) begin
        fails++; $display("FAIL b2b_order: got %h %h %h, expected 00 55 7f", b_got[n0], b_got[n0+1], b_got[n0+2]);
      end
    end
    checks++;
    if (b_ovr_cnt != o0) begin fails++; $display("FAIL b2b_overrun: got %0d, expected 0", b_ovr_cnt - o0); end
    checks++;
    if (b_period !== 8 || b_bad != bad0 || b_rises - r0 < 27) begin
      fails++; $display("FAIL b2b_period: got last=%0d bad=%0d rises=%0d, expected 8 0 >=27", b_period, b_bad - bad0, b_rises - r0);
    end
  endtask

  task automatic test_ruslat_and_reset();
    kbd_ruslat_in = 1'b1;
    tick();
    checks++;
    if (ruslat !== 1'b0) begin fails++; $display("FAIL ruslat_early: got %b, expected 0", ruslat); end
    tick();
    checks++;
    if (ruslat !== 1'b1) begin fails++; $display("FAIL ruslat_rise: got %b, expected 1", ruslat); end
    kbd_ruslat_in = 1'b0;
    tick(); tick();
    checks++;
    if (ruslat !== 1'b0) begin fails++; $display("FAIL ruslat_fall: got %b, expected 0", ruslat); end
    kbd_ruslat_in = 1'b1;
    send_frame(0, 7'h5A, 1'b1);
    send_bits(0, {1'b1, 7'h3C, 1'b0}, 4);
    kbd_reset_in = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({kbd_clock, kbd_reply} !== 2'b11) begin fails++; $display("FAIL midreset_clk_reply: got %b, expected 11", {kbd_clock, kbd_reply}); end
    checks++;
    if ({code, code_valid} !== 8'h00) begin fails++; $display("FAIL midreset_code: got %h, expected 00", {code, code_valid}); end
    checks++;
    if ({overrun, frame_err, kbd_reset, ruslat} !== 4'b0000) begin fails++; $display("FAIL midreset_flags: got %b, expected 0000", {overrun, frame_err, kbd_reset, ruslat}); end
    kbd_reset_in = 1'b1; kbd_ruslat_in = 1'b0; set_data(0, 1'b1);
    reset_n = 1'b1;
    count_first_fall();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_frame_err();
    test_kbd_reset();
    test_back_to_back();
    test_ruslat_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
